// File: rtl/gray_ptr_rx.sv
// ---------------------------------------------------------------------------
// gray_ptr_rx
//   Receive side of a Gray-coded count crossing into the clk domain. The
//   foreign Gray value is passed through a SYNC_STAGES-deep flop chain,
//   converted back to binary and every change is reported as a one-cycle
//   update with its modular increment. Changes that flip more than one Gray
//   bit are flagged, since a well-behaved Gray source never produces them.
//
// Ports
//   clk        : single clock, all logic on posedge
//   rst_n      : asynchronous active-low reset
//   gray_in    : Gray count from a foreign domain (asynchronous to clk)
//   clr_err    : clears err_sticky (an error on the same edge wins)
//   gray_sync  : last synchronizer stage
//   bin_out    : binary value of the last accepted Gray code
//   ready      : baseline captured, outputs meaningful
//   upd        : one-cycle pulse, a new value was accepted
//   delta      : (new_bin - old_bin) mod 2^DW while upd=1, else 0
//   err        : one-cycle pulse, accepted change flipped more than one bit
//   err_sticky : latched err until cleared by clr_err
// ---------------------------------------------------------------------------
module gray_ptr_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] gray_in,
    input  logic          clr_err,
    output logic [DW-1:0] gray_sync,
    output logic [DW-1:0] bin_out,
    output logic          ready,
    output logic          upd,
    output logic [DW-1:0] delta,
    output logic          err,
    output logic          err_sticky
);

    // Counter must be able to hold SYNC_STAGES itself.
    localparam int CW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        WARMUP = 1'b0,
        TRACK  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][DW-1:0]  sync_q;
    logic [DW-1:0]                   prev_q, prev_d;
    logic [DW-1:0]                   bin_q, bin_d;
    logic [DW-1:0]                   delta_q, delta_d;
    logic                            ready_q, ready_d;
    logic                            upd_q, upd_d;
    logic                            err_q, err_d;
    logic                            stk_q, stk_d;

    logic [DW-1:0]                   gs;
    logic [DW-1:0]                   gs_bin;
    logic [DW-1:0]                   gs_diff;
    logic                            multi_bit;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, built MSB-down as a running XOR.
    function automatic logic [DW-1:0] g2b(input logic [DW-1:0] g);
        logic [DW-1:0] b;
        b[DW-1] = g[DW-1];
        for (int i = DW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronizer chain. Only sync_q[0] ever sees the asynchronous input.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign gs      = sync_q[SYNC_STAGES-1];
    assign gs_bin  = g2b(gs);
    assign gs_diff = gs ^ prev_q;
    // More than one bit set <=> nonzero and not a power of two.
    assign multi_bit = (gs_diff & (gs_diff - 1'b1)) != '0;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
            prev_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            ready_q <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            stk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            delta_q <= delta_d;
            ready_q <= ready_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            stk_q   <= stk_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. During WARMUP the chain still holds reset zeros or
    // partially propagated samples, so nothing is reported; the value seen
    // once the chain has been refilled becomes the silent baseline.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        delta_d = '0;
        ready_d = ready_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            WARMUP: begin
                if (cnt_q == CW'(SYNC_STAGES)) begin
                    prev_d  = gs;
                    bin_d   = gs_bin;
                    ready_d = 1'b1;
                    state_d = TRACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRACK: begin
                if (gs != prev_q) begin
                    prev_d  = gs;
                    bin_d   = gs_bin;
                    // Modular difference; direction is left to the consumer.
                    delta_d = gs_bin - bin_q;
                    upd_d   = 1'b1;
                    err_d   = multi_bit;
                end
            end
            default: begin
                state_d = WARMUP;
                cnt_d   = '0;
            end
        endcase

        // A fresh error outranks a clear on the same edge.
        stk_d = err_d | (stk_q & ~clr_err);
    end

    assign gray_sync  = gs;
    assign bin_out    = bin_q;
    assign delta      = delta_q;
    assign ready      = ready_q;
    assign upd        = upd_q;
    assign err        = err_q;
    assign err_sticky = stk_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
module tb_gray_ptr_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] gray_in = 8'h00;

    always #5 clk = ~clk;

    logic [7:0] gs2, bo2, dl2, gs3, bo3, dl3;
    logic       rdy2, upd2, er2, st2, rdy3, upd3, er3, st3;

    gray_ptr_rx #(.DW(8), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
        .gray_sync(gs2), .bin_out(bo2), .ready(rdy2), .upd(upd2),
        .delta(dl2), .err(er2), .err_sticky(st2)
    );

    gray_ptr_rx #(.DW(8), .SYNC_STAGES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
        .gray_sync(gs3), .bin_out(bo3), .ready(rdy3), .upd(upd3),
        .delta(dl3), .err(er3), .err_sticky(st3)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the gray_in value sampled at every edge since reset
    // is kept in hist; what the synchronizer shows is simply an older entry.
    typedef struct {
        bit         ready, upd, err, sticky;
        logic [7:0] bin, delta, prev, gs;
    } mdl_t;

    mdl_t       m2, m3;
    logic [7:0] hist[$];

    typedef struct {
        logic [7:0] g;
        bit         clr;
        logic [7:0] bin, delta;
        bit         err, stk;
    } vec_t;
    vec_t vt[7];

    task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [7:0] mg2b(input logic [7:0] g);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic void mreset(output mdl_t m);
        m.ready = 0; m.upd = 0; m.err = 0; m.sticky = 0;
        m.bin = 0; m.delta = 0; m.prev = 0; m.gs = 0;
    endfunction

    // Called once per edge after hist got this edge's sample (n = edge number).
    function automatic void mstep(inout mdl_t m, input int s, input bit clr);
        int         n = hist.size();
        logic [7:0] gsb, nb;
        gsb     = (n - 1 - s >= 0) ? hist[n-1-s] : 8'h00;
        m.upd   = 0;
        m.err   = 0;
        m.delta = 8'h00;
        if (n == s + 1) begin
            m.prev  = gsb;
            m.bin   = mg2b(gsb);
            m.ready = 1;
        end else if (n > s + 1 && gsb != m.prev) begin
            nb      = mg2b(gsb);
            m.delta = nb - m.bin;
            m.err   = ($countones(gsb ^ m.prev) > 1);
            m.upd   = 1;
            m.prev  = gsb;
            m.bin   = nb;
        end
        m.sticky = m.err ? 1'b1 : (clr ? 1'b0 : m.sticky);
        m.gs     = (n - s >= 0) ? hist[n-s] : 8'h00;
    endfunction

    task automatic check_all();
        chk1("rdy2", rdy2, m2.ready);  chk1("upd2", upd2, m2.upd);
        chk1("err2", er2, m2.err);     chk1("stk2", st2, m2.sticky);
        chk8("bin2", bo2, m2.bin);     chk8("dlt2", dl2, m2.delta);
        chk8("gs2", gs2, m2.gs);
        chk1("rdy3", rdy3, m3.ready);  chk1("upd3", upd3, m3.upd);
        chk1("err3", er3, m3.err);     chk1("stk3", st3, m3.sticky);
        chk8("bin3", bo3, m3.bin);     chk8("dlt3", dl3, m3.delta);
        chk8("gs3", gs3, m3.gs);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mreset(m2); mreset(m3); hist.delete();
        end else begin
            hist.push_back(gray_in);
            mstep(m2, 2, clr_err);
            mstep(m3, 3, clr_err);
        end
        #1;
        check_all();
    endtask

    task automatic chk_zero(input string tag);
        chk8({tag, "_gs2"}, gs2, 8'h00);  chk8({tag, "_bin2"}, bo2, 8'h00);
        chk8({tag, "_dlt2"}, dl2, 8'h00); chk1({tag, "_rdy2"}, rdy2, 1'b0);
        chk1({tag, "_upd2"}, upd2, 1'b0); chk1({tag, "_err2"}, er2, 1'b0);
        chk1({tag, "_stk2"}, st2, 1'b0);  chk8({tag, "_bin3"}, bo3, 8'h00);
        chk1({tag, "_rdy3"}, rdy3, 1'b0); chk1({tag, "_stk3"}, st3, 1'b0);
    endtask

    int         upd_cnt, good_cnt;
    logic [7:0] bb;
    int         r;

    initial begin
        // Directed table, starting from the 0x2A baseline (binary 0x33).
        vt[0] = '{8'h00, 1'b0, 8'h00, 8'hCD, 1'b1, 1'b1};
        vt[1] = '{8'h01, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};
        vt[2] = '{8'h03, 1'b0, 8'h02, 8'h01, 1'b0, 1'b0};
        vt[3] = '{8'h00, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b1};
        vt[4] = '{8'h03, 1'b1, 8'h02, 8'h02, 1'b1, 1'b1};
        vt[5] = '{8'h07, 1'b1, 8'h05, 8'h03, 1'b0, 1'b0};
        vt[6] = '{8'h06, 1'b0, 8'h04, 8'hFF, 1'b0, 1'b0};

        mreset(m2); mreset(m3);

        // Baseline through reset release.
        gray_in = 8'h2A;
        #12;
        chk_zero("rst");
        rst_n = 1'b1;
        tick(); chk1("wu_e1_rdy2", rdy2, 1'b0);
        tick(); chk1("wu_e2_rdy2", rdy2, 1'b0);
        tick(); chk1("wu_e3_rdy2", rdy2, 1'b1); chk8("wu_e3_bin2", bo2, 8'h33);
                chk1("wu_e3_upd2", upd2, 1'b0); chk1("wu_e3_rdy3", rdy3, 1'b0);
        tick(); chk1("wu_e4_rdy3", rdy3, 1'b1); chk8("wu_e4_bin3", bo3, 8'h33);
                chk1("wu_e4_upd2", upd2, 1'b0);
        repeat (3) tick();

        // Table-driven steps: result is visible after edge k+2.
        for (int i = 0; i < 7; i++) begin
            gray_in = vt[i].g;
            clr_err = vt[i].clr;
            repeat (3) tick();
            chk1("vec_upd", upd2, 1'b1);
            chk8("vec_bin", bo2, vt[i].bin);
            chk8("vec_dlt", dl2, vt[i].delta);
            chk1("vec_err", er2, vt[i].err);
            chk1("vec_stk", st2, vt[i].stk);
            clr_err = 1'b0;
            repeat (3) tick();
        end

        // Walk back to gray 0 with single-bit steps, then full sweep.
        gray_in = 8'h04; repeat (4) tick();
        gray_in = 8'h00; repeat (4) tick();
        upd_cnt  = 0;
        good_cnt = 0;
        for (int b = 1; b <= 256; b++) begin
            bb      = 8'(b);
            gray_in = bb ^ (bb >> 1);
            repeat (4) begin
                tick();
                if (upd2) begin
                    upd_cnt++;
                    if (dl2 == 8'h01 && !er2) good_cnt++;
                end
            end
            chk8("sweep_bin", bo2, bb);
        end
        chk8("sweep_upd_cnt", 8'(upd_cnt), 8'(256));
        checks++;
        if (upd_cnt != 256 || good_cnt != 256) begin
            errors++;
            $display("FAIL sweep_pulses: got upd=%0d good=%0d expected 256", upd_cnt, good_cnt);
        end

        // Reset mid-run with bin_out=0x40 and err_sticky=1.
        gray_in = 8'h60; repeat (4) tick();
        chk8("pre_rst_bin", bo2, 8'h40);
        chk1("pre_rst_stk", st2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        mreset(m2); mreset(m3); hist.delete();
        gray_in = 8'h15;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); chk1("re_e1_rdy2", rdy2, 1'b0);
        tick(); chk1("re_e2_rdy2", rdy2, 1'b0);
        tick(); chk1("re_e3_rdy2", rdy2, 1'b1); chk8("re_e3_bin2", bo2, 8'h19);
                chk1("re_e3_upd2", upd2, 1'b0);
        repeat (3) tick();

        // SYNC_STAGES=3 latency on a single step 0x01 -> 0x03.
        gray_in = 8'h01; repeat (6) tick();
        gray_in = 8'h03;
        tick(); chk1("s3_k_upd", upd3, 1'b0);
        tick(); chk1("s3_k1_upd", upd3, 1'b0);
        tick(); chk1("s3_k2_upd", upd3, 1'b0); chk1("s3_k2_upd2", upd2, 1'b1);
        tick(); chk1("s3_k3_upd", upd3, 1'b1); chk8("s3_k3_dlt", dl3, 8'h01);
                chk8("s3_k3_bin", bo3, 8'h02);  chk1("s3_k3_err", er3, 1'b0);
        repeat (3) tick();

        // Random phase, including changes on adjacent edges.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: ;
                1, 2: gray_in = gray_in ^ (8'h01 << $urandom_range(0, 7));
                3: gray_in = 8'($urandom);
                default: begin
                    bb      = mg2b(gray_in) + 8'h01;
                    gray_in = bb ^ (bb >> 1);
                end
            endcase
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
        end
        clr_err = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_ptr_rx.md
# gray_ptr_rx

- Receive-side companion to the binary-to-Gray encoder.
- Takes a Gray-coded count driven from a foreign clock domain and passes it through a multi-flop synchronizer.
- Converts it back to binary and reports each change as an update pulse with a modular increment.
- Flags illegal multi-bit Gray transitions, so the consuming logic (FIFO occupancy, event counters) can trust or reject the value.

## Interface
Parameters:
- DW, 8, width of the Gray/binary count (≥2)
- SYNC_STAGES, 2, synchronizer flop count (≥2)

Ports:
- clk  input  1  single clock; all logic on posedge
- rst_n  input  1  reset; asynchronous and active-low
- gray_in  input  DW  Gray count from another domain, asynchronous to clk
- clr_err  input  1  clears err_sticky
- gray_sync  output  DW  last synchronizer stage
- bin_out  output  DW  registered binary equivalent of the last accepted Gray value
- ready  output  1  baseline captured, outputs valid
- upd  output  1  one-cycle pulse, new value accepted this cycle
- delta  output  DW  (new_bin − old_bin) mod 2^DW when upd=1, else 0
- err  output  1  one-cycle pulse, accepted change differed in >1 bit
- err_sticky  output  1  latched err until clr_err

## Operation
Synchronizer:
- sync[0] <= gray_in, sync[i] <= sync[i-1] each edge.
- gray_sync = sync[SYNC_STAGES-1].

Gray-to-binary:
- b[DW-1] = g[DW-1].
- b[i] = b[i+1] ^ g[i].

FSM states: WARMUP, TRACK.
- Reset enters WARMUP with warmup counter = 0.
- WARMUP: counter increments each edge. When counter reaches SYNC_STAGES, on that edge:
  - prev_gray <= gray_sync
  - bin_out <= g2b(gray_sync)
  - ready <= 1
  - go to TRACK
  - upd and err stay 0 throughout WARMUP.
- TRACK, gray_sync ≠ prev_gray:
  - prev_gray <= gray_sync
  - bin_out <= g2b(gray_sync)
  - delta <= g2b(gray_sync) − bin_out (DW-bit wrap)
  - upd <= 1
  - err <= (popcount(gray_sync ^ prev_gray) > 1)
- TRACK, gray_sync = prev_gray: upd <= 0, err <= 0, delta <= 0, bin_out holds.
- err_sticky:
  - set when err is asserted.
  - otherwise cleared on an edge with clr_err=1.
  - Simultaneous set and clr_err: set wins.
- Outputs are never combinational from gray_in.

## Timing
- Reset (async, while rst_n=0):
  - sync chain, prev_gray, bin_out, delta = 0
  - ready, upd, err, err_sticky = 0
  - state = WARMUP, counter = 0
- Warmup: ready rises after SYNC_STAGES+1 edges following rst_n release. Edge 1 is the first posedge with rst_n=1.
- Latency: a gray_in change captured at edge k appears on gray_sync after edge k+SYNC_STAGES−1. bin_out, upd, delta and err update at edge k+SYNC_STAGES.
- Changes arriving during WARMUP are absorbed into the baseline with no upd.
- Wrap-around: gray 0x80 → 0x00 (DW=8) gives delta=1, err=0.
- A backward step gives delta = 2^DW−1 and err=0. The block does not judge direction.
- Consecutive changes on adjacent edges each produce their own upd pulse; upd may stay high across cycles.
- rst_n asserted mid-operation immediately forces all outputs to their reset values. Release restarts WARMUP.

## Test plan
- Baseline: hold gray_in=0x2A through reset release (DW=8, SYNC_STAGES=2) -> ready=1 after edge 3, bin_out=0x33, no upd/err pulse.
- Sweep: drive gray_in = b^(b>>1) for b=0..255 and back to 0, one step per 4 clks -> 256 upd pulses, each delta=1, bin_out tracks b with 3-edge latency, wrap 0x80→0x00 gives delta=1, err never asserted.
- Illegal jump: from gray 0x00, drive 0x03 -> upd=1, bin_out=0x02, delta=0x02, err pulse=1, err_sticky=1. Then clr_err for 1 cycle -> err_sticky=0 next edge.
- Collision and backward step:
  - Drive clr_err=1 on the same edge as an err pulse -> err_sticky stays 1.
  - Step back from gray 0x07 to 0x06 -> bin_out=0x04, delta=0xFF, err=0.
- Reset mid-run: with bin_out=0x40 and err_sticky=1, pulse rst_n low asynchronously between edges -> all outputs 0 immediately. After release, ready re-rises after 3 edges with the current gray_in as baseline.
- SYNC_STAGES=3: single step 0x01→0x03 -> upd at edge k+3, ready rises after edge 4 post-reset.
